vga_timing_gen: RTL

//  Pixel timing generator that sits directly upstream of vga_controller's colour-gating logic.

---
 rtl/vga_timing_gen_pkg.sv | 40 ++++
 rtl/vga_axis_counter.sv | 62 ++++++
 rtl/vga_timing_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared definitions for the VGA pixel timing generator: 640x480@60 defaults,
// coordinate width, the registered output bundle and the sync level helper.
package vga_timing_gen_pkg;

  localparam int COORD_W = 11;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam logic [COORD_W-1:0] COORD_ONE = {{(COORD_W-1){1'b0}}, 1'b1};

  // Everything the top level presents to vga_controller, registered together
  // so that all fields belong to the same pixel.
  typedef struct packed {
    logic               hs;
    logic               vs;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               de;
    logic               fs;
  } vga_out_t;

  // Drive level of a sync line given whether the pulse is active and its polarity.
  function automatic logic sync_level(input logic active, input logic pol);
    logic lvl;
    if (active) begin
      lvl = pol;
    end else begin
      lvl = ~pol;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical). Holds the position counter and
// decodes the *next* position, so the top level can register outputs that line
// up with the counter value they describe.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int   VIS      = DEF_H_VIS,
  parameter int   FP       = DEF_H_FP,
  parameter int   SYNC_LEN = DEF_H_SYNC,
  parameter int   BP       = DEF_H_BP,
  parameter logic POL      = 1'b0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  output logic               WRAP,
  output logic [COORD_W-1:0] CNT,
  output logic               ACTIVE,
  output logic               SYNC
);

  localparam int TOTAL = VIS + FP + SYNC_LEN + BP;

  localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] VIS_END  = COORD_W'(VIS);
  localparam logic [COORD_W-1:0] SYNC_BEG = COORD_W'(VIS + FP);
  localparam logic [COORD_W-1:0] SYNC_END = COORD_W'(VIS + FP + SYNC_LEN);

  logic [COORD_W-1:0] cnt_r;
  logic [COORD_W-1:0] cnt_next_s;
  logic               wrap_s;
  logic               in_sync_s;

  // Next position: hold when not enabled, otherwise step and wrap after the last position.
  always_comb begin
    wrap_s     = (cnt_r == LAST);
    cnt_next_s = cnt_r;
    if (!EN) begin
      cnt_next_s = cnt_r;
    end else if (wrap_s) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + COORD_ONE;
    end
    in_sync_s = (cnt_next_s >= SYNC_BEG) && (cnt_next_s < SYNC_END);
  end

  // Position register; reset parks it on the last position so the first tick lands on 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r <= LAST;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign WRAP   = wrap_s;
  assign CNT    = cnt_next_s;
  assign ACTIVE = (cnt_next_s < VIS_END);
  assign SYNC   = sync_level(in_sync_s, POL);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel timing generator. Advances one pixel per PIX_EN tick and presents
// HS/VS, 1-based visible coordinates, display enable and a frame-start strobe,
// all registered from the same next-state counter values (zero skew).
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_VIS  = DEF_H_VIS,
  parameter int   H_FP   = DEF_H_FP,
  parameter int   H_SYNC = DEF_H_SYNC,
  parameter int   H_BP   = DEF_H_BP,
  parameter int   V_VIS  = DEF_V_VIS,
  parameter int   V_FP   = DEF_V_FP,
  parameter int   V_SYNC = DEF_V_SYNC,
  parameter int   V_BP   = DEF_V_BP,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PIX_EN,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic [COORD_W-1:0] Current_X,
  output logic [COORD_W-1:0] Current_Y,
  output logic               DISP_EN,
  output logic               FRAME_START
);

  logic               h_wrap_s;
  logic [COORD_W-1:0] h_cnt_s;
  logic               h_act_s;
  logic               h_sync_s;
  logic               v_en_s;
  logic               v_wrap_s;
  logic [COORD_W-1:0] v_cnt_s;
  logic               v_act_s;
  logic               v_sync_s;

  vga_out_t out_next_s;
  vga_out_t out_r;

  assign v_en_s = PIX_EN & h_wrap_s;

  vga_axis_counter #(
    .VIS      (H_VIS),
    .FP       (H_FP),
    .SYNC_LEN (H_SYNC),
    .BP       (H_BP),
    .POL      (HS_POL)
  ) u_h_axis (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (PIX_EN),
    .WRAP   (h_wrap_s),
    .CNT    (h_cnt_s),
    .ACTIVE (h_act_s),
    .SYNC   (h_sync_s)
  );

  vga_axis_counter #(
    .VIS      (V_VIS),
    .FP       (V_FP),
    .SYNC_LEN (V_SYNC),
    .BP       (V_BP),
    .POL      (VS_POL)
  ) u_v_axis (
    .CLK    (CLK),
    .RST    (RST),
    .EN     (v_en_s),
    .WRAP   (v_wrap_s),
    .CNT    (v_cnt_s),
    .ACTIVE (v_act_s),
    .SYNC   (v_sync_s)
  );

  // Output values for the pixel the counters are about to move to.
  always_comb begin
    out_next_s    = '0;
    out_next_s.hs = h_sync_s;
    out_next_s.vs = v_sync_s;
    out_next_s.de = h_act_s & v_act_s;
    // Landing on (0,0) happens exactly when both axes leave their last position.
    out_next_s.fs = h_wrap_s & v_wrap_s;
    if (out_next_s.de) begin
      out_next_s.x = h_cnt_s + COORD_ONE;
      out_next_s.y = v_cnt_s + COORD_ONE;
    end else begin
      out_next_s.x = '0;
      out_next_s.y = '0;
    end
  end

  // Output register: loads only on pixel ticks, otherwise holds the current pixel.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_r    <= '0;
      out_r.hs <= ~HS_POL;
      out_r.vs <= ~VS_POL;
    end else if (PIX_EN) begin
      out_r <= out_next_s;
    end else begin
      out_r <= out_r;
    end
  end

  assign VGA_HS      = out_r.hs;
  assign VGA_VS      = out_r.vs;
  assign Current_X   = out_r.x;
  assign Current_Y   = out_r.y;
  assign DISP_EN     = out_r.de;
  assign FRAME_START = out_r.fs;

endmodule
